// File: rtl/memory_stage.sv
// Stage 4 of the RV32 pipeline: EX/MEM and MEM/WB registers plus the lw/sw
// data-memory handshake, with upstream stall and a request timeout.
module memory_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir4_input,
    input  logic [31:0] pc4_input,
    input  logic [31:0] z4_input,
    input  logic [31:0] md4_input,
    output logic [31:0] ir4_output,
    output logic [31:0] pc4_output,
    output logic [31:0] z4_output,
    output logic [31:0] ir5_output,
    output logic [31:0] pc5_output,
    output logic [31:0] z5_output,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] ir4_q, ir4_d, pc4_q, pc4_d, z4_q, z4_d, md4_q, md4_d;
    logic [31:0] ir5_q, ir5_d, pc5_q, pc5_d, z5_q, z5_d;
    logic        misalign_q, misalign_d, bus_err_q, bus_err_d;

    logic is_lw, is_sw, mem_access, misaligned, mem_op, abort, complete;

    always_comb begin
        is_lw      = (ir4_q[6:0] == 7'b0000011) && (ir4_q[14:12] == 3'b010);
        is_sw      = (ir4_q[6:0] == 7'b0100011) && (ir4_q[14:12] == 3'b010);
        mem_access = is_lw || is_sw;
        misaligned = mem_access && (z4_q[1:0] != 2'b00);
        mem_op     = mem_access && (z4_q[1:0] == 2'b00);
        dmem_req   = (state_q == WAIT) ? 1'b1 : mem_op;
        abort      = (state_q == WAIT) && (cnt_q == TIMEOUT_CNT) && !dmem_ack;
        complete   = dmem_req && dmem_ack;
        stall      = dmem_req && !dmem_ack && !abort;
    end

    // Handshake FSM: IDLE completes zero-wait accesses itself, WAIT counts req cycles.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
        unique case (state_q)
            IDLE: begin
                if (mem_op && !dmem_ack) begin
                    state_d = WAIT;
                    cnt_d   = 8'd1;
                end
            end
            WAIT: begin
                if (dmem_ack) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (abort) begin
                    state_d   = IDLE;
                    cnt_d     = 8'd0;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    always_comb begin
        ir4_d      = ir4_q;
        pc4_d      = pc4_q;
        z4_d       = z4_q;
        md4_d      = md4_q;
        ir5_d      = 32'h0;
        pc5_d      = pc5_q;
        z5_d       = z5_q;
        misalign_d = misalign_q || misaligned;
        if (!stall) begin
            ir4_d = ir4_input;
            pc4_d = pc4_input;
            z4_d  = z4_input;
            md4_d = md4_input;
            ir5_d = (abort || misaligned) ? 32'h0 : ir4_q;
            pc5_d = pc4_q;
            z5_d  = (complete && is_lw) ? dmem_rdata : z4_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            ir4_q      <= 32'h0;
            pc4_q      <= 32'h0;
            z4_q       <= 32'h0;
            md4_q      <= 32'h0;
            ir5_q      <= 32'h0;
            pc5_q      <= 32'h0;
            z5_q       <= 32'h0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ir4_q      <= ir4_d;
            pc4_q      <= pc4_d;
            z4_q       <= z4_d;
            md4_q      <= md4_d;
            ir5_q      <= ir5_d;
            pc5_q      <= pc5_d;
            z5_q       <= z5_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign ir4_output   = ir4_q;
    assign pc4_output   = pc4_q;
    assign z4_output    = z4_q;
    assign ir5_output   = ir5_q;
    assign pc5_output   = pc5_q;
    assign z5_output    = z5_q;
    assign dmem_we      = is_sw;
    assign dmem_addr    = z4_q;
    assign dmem_wdata   = md4_q;
    assign misalign_err = misalign_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with TIMEOUT = 4; each task drives one
// scenario and checks hand-computed values inline.
module tb_memory_stage;

    localparam logic [31:0] ADD = 32'h002081B3;
    localparam logic [31:0] LW  = 32'h00012083;
    localparam logic [31:0] SW  = 32'h00112023;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ir4_input, pc4_input, z4_input, md4_input;
    logic [31:0] ir4_output, pc4_output, z4_output;
    logic [31:0] ir5_output, pc5_output, z5_output;
    logic        stall, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        misalign_err, bus_err;

    int checks = 0;
    int errors = 0;

    memory_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .ir4_input(ir4_input), .pc4_input(pc4_input),
        .z4_input(z4_input), .md4_input(md4_input),
        .ir4_output(ir4_output), .pc4_output(pc4_output), .z4_output(z4_output),
        .ir5_output(ir5_output), .pc5_output(pc5_output), .z5_output(z5_output),
        .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .misalign_err(misalign_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] pc,
                         input logic [31:0] z, input logic [31:0] md);
        ir4_input = ir;
        pc4_input = pc;
        z4_input  = z;
        md4_input = md;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(ADD, 32'h44, 32'h99, 32'h77);
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        tick();
        tick();
        checks++;
        if ({ir4_output, pc4_output, z4_output, ir5_output, pc5_output, z5_output} !== '0) begin
            errors++;
            $display("FAIL reset_regs: got %h %h %h %h %h %h, need all 0",
                     ir4_output, pc4_output, z4_output, ir5_output, pc5_output, z5_output);
        end
        checks++;
        if ({stall, dmem_req, misalign_err, bus_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got stall/req/mis/bus=%b, need 0000",
                     {stall, dmem_req, misalign_err, bus_err});
        end
        reset = 1'b1;
        drive(ADD, 32'h10, 32'h42, 32'h0);
        tick();
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        dmem_ack = 1'b1;  // stray ack with no request must be ignored
        #1;
        checks++;
        if (ir4_output !== ADD || stall !== 1'b0 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL add_ir4: got ir4=%h stall=%b req=%b, need %h 0 0",
                     ir4_output, stall, dmem_req, ADD);
        end
        tick();
        dmem_ack = 1'b0;
        checks++;
        if (ir5_output !== ADD || z5_output !== 32'h42 || pc5_output !== 32'h10) begin
            errors++;
            $display("FAIL add_wb: got ir5=%h z5=%h pc5=%h, need %h 00000042 00000010",
                     ir5_output, z5_output, pc5_output, ADD);
        end
    endtask

    task automatic test_zero_wait_lw();
        drive(LW, 32'h14, 32'h100, 32'h0);
        tick();
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100 || stall !== 1'b0) begin
            errors++;
            $display("FAIL lw0_req: got req=%b we=%b addr=%h stall=%b, need 1 0 00000100 0",
                     dmem_req, dmem_we, dmem_addr, stall);
        end
        tick();
        dmem_ack = 1'b0;
        checks++;
        if (z5_output !== 32'hDEADBEEF || ir5_output !== LW || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL lw0_wb: got z5=%h ir5=%h req=%b, need deadbeef %h 0",
                     z5_output, ir5_output, dmem_req, LW);
        end
    endtask

    task automatic test_wait_sw();
        int stalls = 0;
        int bad = 0;
        drive(SW, 32'h18, 32'h204, 32'h12345678);
        tick();
        drive(ADD, 32'h1C, 32'h55, 32'h0);
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            #1;
            if (stall) stalls++;
            if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_wdata !== 32'h12345678 ||
                dmem_addr !== 32'h204 || ir4_output !== SW || stall !== (i < 3))
                bad++;
            tick();
            if (i < 3 && ir5_output !== 32'h0) bad++;
        end
        dmem_ack = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sw3_hold: %0d bad cycles in req/we/wdata/addr/ir4/bubbles, need 0", bad);
        end
        checks++;
        if (stalls != 3) begin
            errors++;
            $display("FAIL sw3_stalls: got %0d stall cycles, need 3", stalls);
        end
        checks++;
        if (ir5_output !== SW || z5_output !== 32'h204 || pc5_output !== 32'h18 || ir4_output !== ADD) begin
            errors++;
            $display("FAIL sw3_wb: got ir5=%h z5=%h pc5=%h ir4=%h, need %h 00000204 00000018 %h",
                     ir5_output, z5_output, pc5_output, ir4_output, SW, ADD);
        end
    endtask

    task automatic test_back_to_back();
        drive(LW, 32'h20, 32'h108, 32'h0);
        tick();
        drive(SW, 32'h24, 32'h10C, 32'hCAFEF00D);
        dmem_ack = 1'b1;
        dmem_rdata = 32'hA5A5A5A5;
        tick();
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h10C ||
            stall !== 1'b0 || z5_output !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL b2b: got req=%b we=%b addr=%h stall=%b z5=%h, need 1 1 0000010c 0 a5a5a5a5",
                     dmem_req, dmem_we, dmem_addr, stall, z5_output);
        end
        tick();
        dmem_ack = 1'b0;
        checks++;
        if (ir5_output !== SW || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL b2b_sw: got ir5=%h req=%b, need %h 0", ir5_output, dmem_req, SW);
        end
    endtask

    task automatic test_timeout();
        int bad = 0;
        drive(LW, 32'h28, 32'h300, 32'h0);
        tick();
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        dmem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (dmem_req !== 1'b1 || stall !== (i < 4) || bus_err !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_seq: %0d bad cycles in req/stall/bus_err, need 0", bad);
        end
        checks++;
        if (ir5_output !== 32'h0 || bus_err !== 1'b1 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort: got ir5=%h bus_err=%b req=%b, need 0 1 0",
                     ir5_output, bus_err, dmem_req);
        end
        drive(ADD, 32'h2C, 32'h7, 32'h0);
        tick();
        tick();
        checks++;
        if (bus_err !== 1'b1 || ir5_output !== ADD) begin
            errors++;
            $display("FAIL timeout_sticky: got bus_err=%b ir5=%h, need 1 %h", bus_err, ir5_output, ADD);
        end
    endtask

    task automatic test_misaligned();
        int reqs = 0;
        drive(LW, 32'h30, 32'h102, 32'h0);
        tick();
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        #1;
        if (dmem_req) reqs++;
        checks++;
        if (reqs != 0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL mis_req: got req=%b stall=%b, need 0 0", dmem_req, stall);
        end
        tick();
        checks++;
        if (misalign_err !== 1'b1 || ir5_output !== 32'h0 || z5_output !== 32'h102) begin
            errors++;
            $display("FAIL mis_wb: got misalign=%b ir5=%h z5=%h, need 1 0 00000102",
                     misalign_err, ir5_output, z5_output);
        end
    endtask

    task automatic test_reset_mid_wait();
        drive(LW, 32'h34, 32'h400, 32'h0);
        tick();
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        dmem_ack = 1'b0;
        tick();
        tick();
        checks++;
        if (stall !== 1'b1 || dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL midwait_pending: got stall=%b req=%b, need 1 1", stall, dmem_req);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || stall !== 1'b0 || bus_err !== 1'b0 || misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL midwait_reset: got req=%b stall=%b bus=%b mis=%b, need 0 0 0 0",
                     dmem_req, stall, bus_err, misalign_err);
        end
        // IDLE after reset: a zero-wait lw must complete without stalling
        drive(LW, 32'h38, 32'h500, 32'h0);
        tick();
        drive(32'h0, 32'h0, 32'h0, 32'h0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0BADF00D;
        #1;
        checks++;
        if (stall !== 1'b0 || dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL midwait_idle: got stall=%b req=%b, need 0 1", stall, dmem_req);
        end
        tick();
        dmem_ack = 1'b0;
        checks++;
        if (z5_output !== 32'h0BADF00D || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL midwait_after: got z5=%h bus_err=%b, need 0badf00d 0", z5_output, bus_err);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_lw();
        test_wait_sw();
        test_back_to_back();
        test_timeout();
        test_misaligned();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
